logic_unit_seq: RTL and testbench

- Parametrised, multi-operation successor to the team's N-bit bitwise AND gate array.
- Computes one of eight bitwise functions on two N-bit operands, W bits per cycle, LSB slice first.
- Uses a start/busy/done handshake so wide operands share one narrow slice datapath.
- Sits beside the ALU as the logic-op execution unit and is driven by the control FSM.

---
 rtl/logic_unit_pkg.sv | 38 +++
 rtl/logic_slice.sv | 17 +
 rtl/logic_unit_seq.sv | 117 +++++++++++
 tb/tb_logic_unit_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential logic unit: op codes, FSM states and
// the single-bit function used by every bit cell of the slice datapath.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One result bit for the selected function; b is ignored for OP_NOT.
  function automatic logic logic_bit(input logic [2:0] op, input logic a, input logic b);
    logic y;
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_NOT:  y = ~a;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Purely combinational W-bit function unit: one identical cell per bit.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  output logic [W-1:0] y_s
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y_s[i] = logic_bit(op, a_s[i], b_s[i]);
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Sequential logic-op execution unit: latches two N-bit operands on start and
// evaluates the selected bitwise function W bits per cycle, LSB slice first,
// through a single shared slice datapath.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam int N_SLICES = (W > 0) ? N / W : 1;
  localparam int IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  // Reject slice widths that do not tile the operand exactly.
  if (W < 1 || W > N) begin : g_bad_w
    $error("logic_unit_seq: W must satisfy 1 <= W <= N");
  end else if (N % W != 0) begin : g_bad_div
    $error("logic_unit_seq: N must be a multiple of W");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [N-1:0]       result_q, result_d;
  logic               zero_q, zero_d;

  int                 slice_lo;
  logic [W-1:0]       a_s, b_s, y_s;

  // Select the operand slice addressed by the current index.
  assign slice_lo = int'(idx_q) * W;
  assign a_s      = a_q[slice_lo +: W];
  assign b_s      = b_q[slice_lo +: W];

  logic_slice #(.W(W)) u_slice (
    .op  (op_q),
    .a_s (a_s),
    .b_s (b_s),
    .y_s (y_s)
  );

  // Next-state logic: accept in IDLE, write one slice per BUSY cycle, pulse DONE.
  always_comb begin
    // NOTE: every variable gets its hold value before the case so no path leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          idx_d    = '0;
          result_d = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        result_d[slice_lo +: W] = y_s;
        if (idx_q == IDX_W'(N_SLICES - 1)) begin
          zero_d  = (result_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that also aborts an op.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every register sample its pre-edge _d value, independent of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_BUSY);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench: one sliced instance (W=8) and one single-slice
// instance (W=N=32) sharing operands, each with its own start.
module tb_logic_unit_seq;

  logic        clk;
  logic        rst;
  logic        start8, start32;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy8, done8, zero8;
  logic [31:0] result8;
  logic        busy32, done32, zero32;
  logic [31:0] result32;

  int checks = 0;
  int errors = 0;

  logic_unit_seq #(.N(32), .W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .a(a), .b(b),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8)
  );

  logic_unit_seq #(.N(32), .W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
    .busy(busy32), .done(done32), .result(result32), .zero(zero32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Whole-word reference for the eight functions.
  function automatic logic [31:0] ref_fn(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return ~x;
    endcase
  endfunction

  task automatic set_start(input bit use32, input logic v);
    if (use32) start32 = v; else start8 = v;
  endtask

  // Issue one op on the chosen instance and watch the full handshake.
  // t counts negedges after the accepting edge; done is due at t == slices.
  task automatic run_op(input bit use32, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input bit disturb, input string tag,
                        input logic [31:0] exp, input logic exp_z);
    int          n, done_cnt, busy_cnt, done_t;
    logic        c_busy, c_done, c_zero, z_at_done, busy_at_done, zero_after;
    logic [31:0] c_res, res_at_done, res_after, res_t0;
    n = use32 ? 1 : 4;
    done_cnt = 0; busy_cnt = 0; done_t = -1;
    res_at_done = '0; z_at_done = 1'b0; busy_at_done = 1'b1;
    res_after = '0; zero_after = 1'b1; res_t0 = 32'hFFFF_FFFF;
    @(negedge clk);
    op = o; a = av; b = bv;
    set_start(use32, 1'b1);
    @(negedge clk);
    set_start(use32, 1'b0);
    for (int t = 0; t <= n + 3; t++) begin
      if (t > 0) @(negedge clk);
      c_busy = use32 ? busy32 : busy8;
      c_done = use32 ? done32 : done8;
      c_zero = use32 ? zero32 : zero8;
      c_res  = use32 ? result32 : result8;
      if (t == 0) res_t0 = c_res;
      if (c_busy) busy_cnt++;
      if (c_done) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t = t; res_at_done = c_res; z_at_done = c_zero; busy_at_done = c_busy;
        end
      end
      if (t == n + 1) begin
        res_after = c_res; zero_after = c_zero;
      end
      if (disturb) begin
        if (t >= 1 && t <= n) begin
          set_start(use32, 1'b1);
          a = $urandom; b = $urandom; op = 3'($urandom);
        end else begin
          set_start(use32, 1'b0);
        end
      end
    end
    set_start(use32, 1'b0);
    check({tag, " cleared_on_start"}, res_t0, 32'h0);
    check({tag, " done_latency"}, done_t, n);
    check({tag, " busy_cycles"}, busy_cnt, n);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_with_done"}, busy_at_done, 1'b0);
    check({tag, " result"}, res_at_done, exp);
    check({tag, " zero"}, z_at_done, exp_z);
    check({tag, " result_held"}, res_after, exp);
    check({tag, " zero_after_done"}, zero_after, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          dcount;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rexp;

    vecs[0] = '{3'b000, 32'hF0F0_AAAA, 32'hFF00_0F0F, 32'hF000_0A0A, 1'b0};
    vecs[1] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{3'b000, 32'h1234_5678, 32'h0F0F_F0F0, 32'h0204_5070, 1'b0};
    vecs[3] = '{3'b001, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1F3F_F6F8, 1'b0};
    vecs[4] = '{3'b010, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1D3B_A688, 1'b0};
    vecs[5] = '{3'b011, 32'h1234_5678, 32'h0F0F_F0F0, 32'hFDFB_AF8F, 1'b0};
    vecs[6] = '{3'b100, 32'h1234_5678, 32'h0F0F_F0F0, 32'hE0C0_0907, 1'b0};
    vecs[7] = '{3'b101, 32'h1234_5678, 32'h0F0F_F0F0, 32'hE2C4_5977, 1'b0};
    vecs[8] = '{3'b110, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1030_0608, 1'b0};
    vecs[9] = '{3'b111, 32'h1234_5678, 32'h0F0F_F0F0, 32'hEDCB_A987, 1'b0};

    // Reset held two cycles while start is asserted.
    rst = 1'b1; start8 = 1'b1; start32 = 1'b1;
    op = 3'b000; a = 32'hF0F0_AAAA; b = 32'hFF00_0F0F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy8", busy8, 1'b0);
    check("reset done8", done8, 1'b0);
    check("reset result8", result8, 32'h0);
    check("reset zero8", zero8, 1'b0);
    check("reset busy32", busy32, 1'b0);
    check("reset result32", result32, 32'h0);
    rst = 1'b0; start8 = 1'b0; start32 = 1'b0;
    @(negedge clk);
    check("post_reset idle8", busy8, 1'b0);
    check("post_reset idle32", busy32, 1'b0);

    // Directed table on both instances.
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d w8", i),
             vecs[i].exp, vecs[i].exp_zero);
      run_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d w32", i),
             vecs[i].exp, vecs[i].exp_zero);
    end

    // start and operand changes during BUSY/DONE are ignored.
    run_op(1'b0, 3'b000, 32'hF0F0_AAAA, 32'hFF00_0F0F, 1'b1, "disturb w8",
           32'hF000_0A0A, 1'b0);

    // Mid-op reset on the second BUSY cycle aborts without done.
    @(negedge clk);
    op = 3'b000; a = 32'hF0F0_AAAA; b = 32'hFF00_0F0F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    check("midop in_busy", busy8, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midop busy", busy8, 1'b0);
    check("midop done", done8, 1'b0);
    check("midop result", result8, 32'h0);
    dcount = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done8 || busy8) dcount++;
    end
    check("midop no_done", dcount, 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rexp = ref_fn(ro, ra, rb);
      run_op(i[0], ro, ra, rb, 1'b0, $sformatf("rand%0d", i), rexp, rexp == 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
